mem_port_arbiter: RTL and testbench

Sequencer that shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester and its MEM-stage data requester. It sits between the IF/MEM combinational stages and the single memory, latches and holds each transaction until the memory handshakes, and returns registered results. It drives the stall signals that freeze the pipeline while a requester waits. Data accesses have priority, and a one-cycle completion mask prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_sat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types for the unified memory port arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : increments once per cycle of inc, holds at all-ones
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one variable-latency memory port between fetch
//                    and data requesters; data has priority
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] if_wait_cnt,
    output logic [CW-1:0] d_wait_cnt
);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    req_id_t       w_owner;
    logic          w_busy;
    logic          w_done;
    logic          w_if_elig;
    logic          w_d_elig;

    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_if_valid;
    logic          r_d_valid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    // A requester is masked while its own valid is high so it cannot re-grant
    // on the request it is still holding from the completed transaction.
    assign w_if_elig = if_req & ~r_if_valid;
    assign w_d_elig  = d_req  & ~r_d_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_d_elig) begin
                    w_state_next = DBUSY;
                end else if (w_if_elig) begin
                    w_state_next = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_owner = REQ_IF;
        unique case (r_state)
            IBUSY: begin
                w_busy  = 1'b1;
                w_owner = REQ_IF;
            end
            DBUSY: begin
                w_busy  = 1'b1;
                w_owner = REQ_D;
            end
            default: begin
                w_busy  = 1'b0;
                w_owner = REQ_IF;
            end
        endcase
    end

    assign w_done = w_busy & mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_d_elig) begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_wdata <= d_wdata;
                end else if (w_if_elig) begin
                    r_addr  <= if_addr;
                    r_we    <= 1'b0;
                end
            end
            r_if_valid <= w_done && (w_owner == REQ_IF);
            r_d_valid  <= w_done && (w_owner == REQ_D);
            if (w_done && (w_owner == REQ_IF)) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_done && (w_owner == REQ_D) && !r_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = r_we & w_busy;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;

    assign stall_if  = if_req & ~r_if_valid;
    assign stall_mem = d_req  & ~r_d_valid;

    sat_counter #(.CW(CW)) u_if_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_if),
        .count (if_wait_cnt)
    );

    sat_counter #(.CW(CW)) u_d_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_mem),
        .count (d_wait_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] if_wait_cnt;
    logic [CW-1:0] d_wait_cnt;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_valid    (if_valid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_valid     (d_valid),
        .d_rdata     (d_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .if_wait_cnt (if_wait_cnt),
        .d_wait_cnt  (d_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // Leaves the bench just after a non-reset edge with the DUT idle.
    task automatic do_reset;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        cyc();
        cyc();
        smp();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state
        do_reset();
        smp();
        check_eq("rst_mem_req",  mem_req,     0);
        check_eq("rst_if_valid", if_valid,    0);
        check_eq("rst_d_valid",  d_valid,     0);
        check_eq("rst_if_rdata", if_rdata,    0);
        check_eq("rst_d_rdata",  d_rdata,     0);
        check_eq("rst_mem_addr", mem_addr,    0);
        check_eq("rst_if_cnt",   if_wait_cnt, 0);
        check_eq("rst_d_cnt",    d_wait_cnt,  0);

        // Zero-wait fetch: mem_req in cycle 1, if_valid in cycle 2
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h100;
        mem_ready = 1'b1;
        mem_rdata = 32'h2008_0005;
        smp();
        check_eq("f_c0_mem_req", mem_req, 0);
        check_eq("f_c0_stall",   stall_if, 1);
        cyc();
        smp();
        check_eq("f_c1_mem_req", mem_req, 1);
        check_eq("f_c1_addr",    mem_addr, 32'h100);
        check_eq("f_c1_we",      mem_we, 0);
        check_eq("f_c1_stall",   stall_if, 1);
        cyc();
        smp();
        check_eq("f_c2_valid",   if_valid, 1);
        check_eq("f_c2_rdata",   if_rdata, 32'h2008_0005);
        check_eq("f_c2_stall",   stall_if, 0);
        check_eq("f_c2_mem_req", mem_req, 0);
        check_eq("f_c2_cnt",     if_wait_cnt, 2);
        cyc();
        if_req = 1'b0;
        smp();
        check_eq("f_c3_valid",   if_valid, 0);
        check_eq("f_c3_mem_req", mem_req, 0);

        // Simultaneous requests: data first, fetch granted in the d_valid cycle
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h40;
        if_req    = 1'b1;
        if_addr   = 32'h104;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        cyc();
        smp();
        check_eq("p_c1_addr",    mem_addr, 32'h40);
        check_eq("p_c1_mem_req", mem_req, 1);
        check_eq("p_c1_we",      mem_we, 0);
        cyc();
        smp();
        check_eq("p_c2_dvalid",  d_valid, 1);
        check_eq("p_c2_drdata",  d_rdata, 32'h1111_2222);
        check_eq("p_c2_ivalid",  if_valid, 0);
        check_eq("p_c2_stall",   stall_if, 1);
        cyc();
        d_req     = 1'b0;
        mem_rdata = 32'h3333_4444;
        smp();
        check_eq("p_c3_mem_req", mem_req, 1);
        check_eq("p_c3_addr",    mem_addr, 32'h104);
        check_eq("p_c3_dvalid",  d_valid, 0);
        cyc();
        smp();
        check_eq("p_c4_ivalid",  if_valid, 1);
        check_eq("p_c4_irdata",  if_rdata, 32'h3333_4444);
        check_eq("p_c4_drdata",  d_rdata, 32'h1111_2222);
        cyc();
        if_req = 1'b0;

        // Store with three wait cycles; inputs change after grant
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h80;
        d_wdata   = 32'hDEAD_BEEF;
        mem_ready = 1'b0;
        mem_rdata = 32'h5555_5555;
        cyc();
        d_addr  = 32'h99;
        d_wdata = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) mem_ready = 1'b1;
            smp();
            check_eq($sformatf("s_c%0d_mem_req", i), mem_req, 1);
            check_eq($sformatf("s_c%0d_we", i),      mem_we, 1);
            check_eq($sformatf("s_c%0d_addr", i),    mem_addr, 32'h80);
            check_eq($sformatf("s_c%0d_wdata", i),   mem_wdata, 32'hDEAD_BEEF);
            check_eq($sformatf("s_c%0d_dvalid", i),  d_valid, 0);
            cyc();
        end
        smp();
        check_eq("s_c5_dvalid",  d_valid, 1);
        check_eq("s_c5_drdata",  d_rdata, 0);
        check_eq("s_c5_cnt",     d_wait_cnt, 5);
        check_eq("s_c5_mem_req", mem_req, 0);
        cyc();
        d_req = 1'b0;
        smp();
        check_eq("s_c6_dvalid",  d_valid, 0);
        check_eq("s_c6_cnt",     d_wait_cnt, 5);

        // d_req held through d_valid with a new address: no re-issue in valid cycle
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h200;
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        cyc();
        smp();
        check_eq("h_c1_addr", mem_addr, 32'h200);
        cyc();
        d_addr = 32'h300;
        smp();
        check_eq("h_c2_dvalid",  d_valid, 1);
        check_eq("h_c2_mem_req", mem_req, 0);
        cyc();
        smp();
        check_eq("h_c3_mem_req", mem_req, 0);
        check_eq("h_c3_dvalid",  d_valid, 0);
        cyc();
        smp();
        check_eq("h_c4_mem_req", mem_req, 1);
        check_eq("h_c4_addr",    mem_addr, 32'h300);
        cyc();
        d_req = 1'b0;

        // Reset while DBUSY with the memory stalled
        do_reset();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h40;
        mem_ready = 1'b0;
        cyc();
        smp();
        check_eq("r_c1_mem_req", mem_req, 1);
        cyc();
        rst_n = 1'b0;
        d_req = 1'b0;
        cyc();
        smp();
        check_eq("r_c3_mem_req", mem_req, 0);
        check_eq("r_c3_dvalid",  d_valid, 0);
        check_eq("r_c3_dcnt",    d_wait_cnt, 0);
        check_eq("r_c3_icnt",    if_wait_cnt, 0);
        rst_n = 1'b1;
        cyc();
        smp();
        check_eq("r_c4_mem_req", mem_req, 0);
        check_eq("r_c4_dvalid",  d_valid, 0);

        // Counter saturation at 15 with CW=4
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h400;
        mem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 14) begin
                smp();
                check_eq("c_14", if_wait_cnt, 14);
            end
            if (i == 15) begin
                smp();
                check_eq("c_15", if_wait_cnt, 15);
            end
        end
        smp();
        check_eq("c_20",     if_wait_cnt, 15);
        check_eq("c_20_req", mem_req, 1);
        check_eq("c_20_val", if_valid, 0);
        cyc();
        cyc();
        smp();
        check_eq("c_22", if_wait_cnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
